// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised single-port RAM: controller state
// encoding, default geometry and the parity helper used by the optional
// RAM_PARITY_EN build.
package ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Even parity (XOR of all bits); callers zero-extend data to 64 bits.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_sweep_ctrl.sv
// Sweep controller for ram_sync_param: owns the INIT/IDLE state, the clear
// sweep pointer, the ready/busy decode and the array write-port mux.
module ram_sweep_ctrl
    import ram_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          req,
    input  logic          rw,
    input  logic [AW-1:0] address,
    input  logic          wipe,
    output logic          ready,
    output logic          busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic          mem_zero,
    output logic          rd_en,
    output logic          addr_ok
);

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic          accept;

    // State and sweep pointer; clear restarts the sweep from word 0.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next state: sweep walks every word once, wipe re-enters the sweep.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_INIT: begin
                if (ptr == LAST) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (wipe) begin
                    state_nxt = ST_INIT;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Outputs: sweep owns the write port in INIT; wipe masks a same-cycle req.
    always_comb begin
        ready    = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        addr_ok  = ({1'b0, address} < DEPTH_W);
        accept   = (state == ST_IDLE) && !wipe && req;
        mem_we   = 1'b0;
        mem_addr = address;
        mem_zero = 1'b0;
        rd_en    = 1'b0;
        if (state == ST_INIT) begin
            mem_we   = 1'b1;
            mem_addr = ptr;
            mem_zero = 1'b1;
        end else if (accept) begin
            if (rw) begin
                mem_we = addr_ok;
            end else begin
                rd_en = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised synchronous single-port RAM (WIDTH x DEPTH) with req/ready
// handshake, registered read plus valid strobe and a hardware clear sweep.
// Optional build macro RAM_PARITY_EN adds a stored even-parity bit, a write
// parity-inject input and a read parity-error output (WIDTH <= 64).
module ram_sync_param
    import ram_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req,
    input  logic             rw,
    input  logic [AW-1:0]    address,
    input  logic [WIDTH-1:0] i,
    input  logic             wipe,
`ifdef RAM_PARITY_EN
    input  logic             perr_inject,
    output logic             perr,
`endif
    output logic [WIDTH-1:0] o,
    output logic             valid,
    output logic             ready,
    output logic             busy
);

`ifdef RAM_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    logic [MW-1:0] mem [DEPTH];
    logic          mem_we, mem_zero, rd_en, addr_ok;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] wr_word, rd_word;

    ram_sweep_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ctrl (
        .clock    (clock),
        .clear    (clear),
        .req      (req),
        .rw       (rw),
        .address  (address),
        .wipe     (wipe),
        .ready    (ready),
        .busy     (busy),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_zero (mem_zero),
        .rd_en    (rd_en),
        .addr_ok  (addr_ok)
    );

    // Write word: zeros during the sweep (parity 0 is correct for zero data).
    always_comb begin
        wr_word = '0;
        if (!mem_zero) begin
`ifdef RAM_PARITY_EN
            wr_word = {even_parity(64'(i)) ^ perr_inject, i};
`else
            wr_word = i;
`endif
        end
        rd_word = addr_ok ? mem[address] : '0;
    end

    // Storage array; no reset, contents are defined by the sweep.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= wr_word;
        end
    end

    // Read register: o holds the last read; out-of-range reads return zero.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            o     <= '0;
            valid <= 1'b0;
`ifdef RAM_PARITY_EN
            perr  <= 1'b0;
`endif
        end else begin
            valid <= rd_en;
            if (rd_en) begin
                o <= addr_ok ? rd_word[WIDTH-1:0] : '0;
            end
`ifdef RAM_PARITY_EN
            perr <= rd_en && addr_ok &&
                    (rd_word[WIDTH] != even_parity(64'(rd_word[WIDTH-1:0])));
`endif
        end
    end

endmodule

// File: doc/ram_sync_param.md
# ram_sync_param

Parametrised synchronous single-port RAM, WIDTH bits × DEPTH words, replacing the fixed 4×8 RAM assembled from 2×8 banks. It adds a request/ready handshake, a registered read with a valid strobe, and a hardware clear sweep that zeroes every word after reset or on command. It sits between the datapath register file and the memory-test harness and is the storage primitive for the following guides.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of words (≥2, need not be a power of two)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- clock  input  1  sole clock, rising edge
- clear  input  1  asynchronous, active-low reset
- req  input  1  access request, sampled on clock edge
- rw  input  1  1 = write, 0 = read (qualified by req)
- address  input  AW  word address
- i  input  WIDTH  write data
- wipe  input  1  synchronous command: zero whole array
- o  output  WIDTH  read data, registered
- valid  output  1  one-cycle strobe, o holds fresh read data
- ready  output  1  block accepts req/wipe this cycle
- busy  output  1  clear sweep in progress (= !ready)
- perr_inject  input  1  only with RAM_PARITY_EN
- perr  output  1  only with RAM_PARITY_EN

## Operation
- States: INIT (sweep), IDLE. Encoding in the package.
- clear low (async): state←INIT, sweep pointer←0, o←0, valid←0, perr←0; ready=0, busy=1 immediately.
- INIT: each edge writes 0 to mem[ptr], ptr++. On the edge writing ptr=DEPTH-1: state←IDLE, ptr←0. req and wipe ignored.
- IDLE, wipe=1: state←INIT; wipe has priority over a same-cycle req (req dropped, no write, no valid).
- IDLE, req=1, rw=1: mem[address]←i on that edge. valid stays 0.
- IDLE, req=1, rw=0: o←mem[address], valid←1 on that edge; valid←0 next edge unless another read is accepted.
- o holds last read value between reads; not altered by writes or sweep (sweep clears only the array; o is cleared only by clear).
- address ≥ DEPTH: write discarded; read returns o=0 with valid=1.
- Write followed by read of same address on next cycle returns the new data (no hazard; write completes at edge).
- clear asserted mid-sweep or mid-access: aborts, sweep restarts from 0 after release.

## Timing
- Read latency: 1 cycle (req at edge n → o/valid visible after edge n).
- Back-to-back reads at full rate; valid stays high continuously.
- Sweep: exactly DEPTH cycles; after clear release, ready rises after edge DEPTH. Same for wipe accepted at edge n: ready=0 after edge n, ready=1 after edge n+DEPTH.
- ready, busy are combinational decodes of state (no req→ready path).

## Configuration
- RAM_PARITY_EN defined: array stores WIDTH+1 bits, extra bit = even parity of data (XOR of data bits). Write with perr_inject=1 stores inverted parity. On read, perr←(stored parity ≠ recomputed), asserted with valid, cleared with valid. Sweep writes parity 0 (correct for zero data). Ports perr_inject, perr present.
- Not defined: array WIDTH bits, perr_inject and perr ports absent, no parity logic.

## Structure
- Package ram_pkg: state enum (ST_INIT, ST_IDLE), default WIDTH/DEPTH constants, parity function.
- One sub-module: ram_sweep_ctrl (state register, sweep pointer, ready/busy decode, write-enable/address mux to the array). Array and read register stay in the top.

## Test plan
- Reset, DEPTH=4: release clear → ready=0 for 4 cycles, rises after 4th edge; read all addresses → o=0x00, valid=1 each.
- Write 0xA5 to addr 2, read addr 2 next cycle → o=0xA5 after one edge, valid pulses one cycle; reads of 0,1,3 → 0x00.
- wipe and req(write 0xFF, addr 1) in same IDLE cycle → write dropped, 4-cycle sweep, then read addr 1 → 0x00; o retains pre-wipe value until that read.
- DEPTH=5, WIDTH=16: write 0x1234 to addr 6 → ignored; read addr 6 → o=0x0000, valid=1; addr 4 read/write works.
- Assert clear mid-sweep (cycle 2) → busy stays 1, ready rises exactly DEPTH cycles after release; o=0, valid=0.
- RAM_PARITY_EN: write 0x0F with perr_inject=1 to addr 0, 0x0F normal to addr 1 → read 0: perr=1; read 1: perr=0.
